// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with per-word parity/framing flags and a valid/ready receive FIFO.
// Optional break detection is compiled in with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int OVERSAMPLING = 16,
   parameter int PARITY_MODE  = 1,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          baud,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          m_data,
   output logic                          m_parity_err,
   output logic                          m_frame_err,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy,
   output logic                          overrun,
   input  logic                          err_clr,
   output logic                          break_det
);
   localparam int OSW = $clog2(OVERSAMPLING);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int WW  = DATA_BITS + 2;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   logic                 rx_meta_q, rx_s_q;
   state_t               state_q;
   logic [OSW-1:0]       os_q;
   logic [3:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q, ferr_q;
   logic                 push_q;
   logic [WW-1:0]        word_q;

   logic os_half_w, os_full_w, last_stop_w, ferr_w, perr_w;

   always_ff @(posedge baud or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign os_half_w   = (os_q == OSW'(OVERSAMPLING/2 - 1));
   assign os_full_w   = (os_q == OSW'(OVERSAMPLING - 1));
   assign last_stop_w = (bit_q == 4'(STOP_BITS - 1));
   assign ferr_w      = ferr_q | ~rx_s_q;

   always_comb begin
      perr_w = 1'b0;
      if (PARITY_MODE == 1)      perr_w = ^{shift_q, par_q};
      else if (PARITY_MODE == 2) perr_w = ~^{shift_q, par_q};
   end

`ifdef UART_RX_BREAK_DETECT_EN
   logic break_q, is_break_w;
   assign is_break_w = (shift_q == '0) && ((PARITY_MODE == 0) || !par_q) && ferr_w;
   assign break_det  = break_q;
`else
   assign break_det  = 1'b0;
`endif

   always_ff @(posedge baud or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         os_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         ferr_q  <= 1'b0;
         push_q  <= 1'b0;
         word_q  <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
         break_q <= 1'b0;
`endif
      end else begin
         push_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         break_q <= 1'b0;
`endif
         if (!enable) begin
            state_q <= IDLE;
            os_q    <= '0;
            bit_q   <= '0;
         end else begin
            case (state_q)
               IDLE: if (!rx_s_q) begin
                  state_q <= START;
                  os_q    <= '0;
               end
               START: if (os_half_w) begin
                  os_q   <= '0;
                  bit_q  <= '0;
                  ferr_q <= 1'b0;
                  state_q <= rx_s_q ? IDLE : DATA;
               end else os_q <= os_q + 1'b1;
               DATA: if (os_full_w) begin
                  os_q    <= '0;
                  shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                  if (bit_q == 4'(DATA_BITS - 1)) begin
                     bit_q   <= '0;
                     state_q <= (PARITY_MODE == 0) ? STOP : PARITY;
                  end else bit_q <= bit_q + 1'b1;
               end else os_q <= os_q + 1'b1;
               PARITY: if (os_full_w) begin
                  os_q    <= '0;
                  par_q   <= rx_s_q;
                  state_q <= STOP;
               end else os_q <= os_q + 1'b1;
               STOP: if (os_full_w) begin
                  os_q <= '0;
                  if (last_stop_w) begin
                     bit_q   <= '0;
                     state_q <= IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                     if (is_break_w) begin
                        break_q <= 1'b1;
                        state_q <= BRK;
                     end else begin
                        push_q <= 1'b1;
                        word_q <= {perr_w, ferr_w, shift_q};
                     end
`else
                     push_q <= 1'b1;
                     word_q <= {perr_w, ferr_w, shift_q};
`endif
                  end else begin
                     bit_q  <= bit_q + 1'b1;
                     ferr_q <= ferr_w;
                  end
               end else os_q <= os_q + 1'b1;
               // A break holds the line low; wait for it to release so only one pulse fires.
               BRK: if (rx_s_q) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy = (state_q != IDLE);

   logic [WW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          overrun_q;
   logic          pop_w, full_w, wr_en_w;

   assign pop_w   = (count_q != '0) && m_ready;
   assign full_w  = (count_q == (AW+1)'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot the full FIFO would otherwise refuse.
   assign wr_en_w = push_q && (!full_w || pop_w);

   always_ff @(posedge baud or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_en_w) begin
            mem_q[wr_ptr_q] <= word_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_w) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en_w, pop_w})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (err_clr)                 overrun_q <= 1'b0;
         else if (push_q && !wr_en_w) overrun_q <= 1'b1;
      end
   end

   assign m_data       = mem_q[rd_ptr_q][DATA_BITS-1:0];
   assign m_frame_err  = mem_q[rd_ptr_q][WW-2];
   assign m_parity_err = mem_q[rd_ptr_q][WW-1];
   assign m_valid      = (count_q != '0);
   assign fifo_count   = count_q;
   assign overrun      = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at default parameters (8 data bits, even parity, 1 stop, x16).
// The break scenario runs only when UART_RX_BREAK_DETECT_EN is defined.
module tb_uart_rx_fifo;
   localparam int OS = 16;

   logic       baud = 1'b0;
   logic       rst_n, enable, rx, m_ready, err_clr;
   logic [7:0] m_data;
   logic       m_parity_err, m_frame_err, m_valid, busy, overrun, break_det;
   logic [2:0] fifo_count;

   typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   brk_cnt  = 0;

   uart_rx_fifo dut (
      .baud(baud), .rst_n(rst_n), .enable(enable), .rx(rx),
      .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
      .m_valid(m_valid), .m_ready(m_ready), .fifo_count(fifo_count),
      .busy(busy), .overrun(overrun), .err_clr(err_clr), .break_det(break_det)
   );

   always #5 baud = ~baud;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge baud);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      cycles(OS);
   endtask

   // Start, 8 data LSB first, parity bit, stop bit, then one idle bit time.
   task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input bit expect_push);
      exp_t e;
      if (expect_push) begin
         e.d  = d;
         e.pe = (^d) ^ pb;
         e.fe = ~sb;
         exp_q.push_back(e);
      end
      $display("send data=%02h parity=%0b stop=%0b push=%0b", d, pb, sb, expect_push);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(pb);
      send_bit(sb);
      send_bit(1'b1);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || fifo_count != 0) && n < 200) begin
         cycles(1);
         n++;
      end
      check({name, "_drain_timeout"}, (n < 200) ? 32'd1 : 32'd0, 32'd1);
      check({name, "_fifo_count"}, 32'(fifo_count), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; rx = 1'b1; m_ready = 1'b1; err_clr = 1'b0;

      fork
         forever begin
            @(negedge baud);
            if (break_det) brk_cnt++;
            if (rst_n && m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pop", 32'(m_data), 32'hFFFF_FFFF);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  $display("pop data=%02h perr=%0b ferr=%0b (exp %02h %0b %0b)",
                           m_data, m_parity_err, m_frame_err, e.d, e.pe, e.fe);
                  check("pop_data", 32'(m_data), 32'(e.d));
                  check("pop_perr", 32'(m_parity_err), 32'(e.pe));
                  check("pop_ferr", 32'(m_frame_err), 32'(e.fe));
               end
            end
         end
         begin
            #400000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog expired");
         end
      join_none

      cycles(3);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_break_det", 32'(break_det), 32'd0);
      rst_n = 1'b1;
      cycles(5);

      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      wait_drain("clean");
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      wait_drain("bad_parity");
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      wait_drain("bad_stop");
      check("bad_stop_idle_busy", 32'(busy), 32'd0);

      m_ready = 1'b0;
      send_frame(8'h01, 1'b1, 1'b1, 1'b1);
      send_frame(8'h02, 1'b1, 1'b1, 1'b1);
      send_frame(8'h03, 1'b0, 1'b1, 1'b1);
      send_frame(8'h04, 1'b1, 1'b1, 1'b1);
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_no_overrun", 32'(overrun), 32'd0);
      send_frame(8'h05, 1'b0, 1'b1, 1'b0);
      check("ovr_count", 32'(fifo_count), 32'd4);
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_head", 32'(m_data), 32'h01);
      m_ready = 1'b1;
      wait_drain("overrun");
      check("ovr_sticky", 32'(overrun), 32'd1);
      err_clr = 1'b1;
      cycles(1);
      err_clr = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);

      rx = 1'b0;
      cycles(4);
      check("glitch_busy", 32'(busy), 32'd1);
      rx = 1'b1;
      cycles(40);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_count", 32'(fifo_count), 32'd0);

      rx = 1'b0;
      cycles(4 * OS + OS / 2);
      check("abort_busy", 32'(busy), 32'd1);
      enable = 1'b0;
      cycles(1);
      check("abort_idle", 32'(busy), 32'd0);
      rx = 1'b1;
      cycles(20);
      enable = 1'b1;
      cycles(20);
      check("abort_count", 32'(fifo_count), 32'd0);
      send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
      wait_drain("after_abort");

`ifdef UART_RX_BREAK_DETECT_EN
      brk_cnt = 0;
      rx = 1'b0;
      cycles(12 * OS);
      rx = 1'b1;
      cycles(40);
      check("break_pulses", 32'(brk_cnt), 32'd1);
      check("break_count", 32'(fifo_count), 32'd0);
      check("break_idle", 32'(busy), 32'd0);
      send_frame(8'h42, 1'b0, 1'b1, 1'b1);
      wait_drain("after_break");
`else
      check("no_break_pulses", 32'(brk_cnt), 32'd0);
`endif

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver for the monitor FPGA. Runs on the oversampled baud clock and supports configurable data width, parity mode and stop-bit count. Received words go into an internal FIFO with a valid/ready output interface. Each word carries its own parity and framing error flags; a sticky overrun flag reports words dropped on a full FIFO. The block sits between the rx pin and the command/monitor logic.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLING, 16, baud clock cycles per bit (even, >=4)
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
baud  in  1  oversampled baud clock; the only clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  receiver enable; low aborts the current frame synchronously
rx  in  1  asynchronous serial line, idle high
m_data  out  DATA_BITS  FIFO head data word
m_parity_err  out  1  parity error flag of the head word (0 when PARITY_MODE=0)
m_frame_err  out  1  stop-bit error flag of the head word
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts the head word when m_valid && m_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; a frame was dropped because the FIFO was full
err_clr  in  1  clears overrun (clear takes priority over a set in the same cycle)
break_det  out  1  one-cycle pulse on break (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; sync flops = 1.
- rx passes through a 2-flop synchronizer (rx_s) before use; this adds 2 cycles of latency.
- State IDLE: when rx_s = 0, go to START with os_cnt = 0.
- State START: os_cnt counts to OVERSAMPLING/2-1, then checks rx_s.
  - rx_s = 1 at that point is a false start: go to IDLE with no error and no push.
  - Otherwise go to DATA with os_cnt = 0 and bit_cnt = 0.
- State DATA: sample rx_s when os_cnt = OVERSAMPLING-1, then os_cnt wraps to 0.
  - Shift the sample in LSB-first.
  - After DATA_BITS samples, go to PARITY, or go to STOP if PARITY_MODE = 0.
- State PARITY: sample at the bit middle.
  - perr = (XOR of data and parity bit) != 0 for even parity; == 0 for odd parity.
  - Always continue to STOP. A parity error does not abandon the frame.
- State STOP: sample each of the STOP_BITS bits at its middle; any 0 sets ferr.
  - After the last stop-bit sample, push {perr, ferr, data} into the FIFO and go to IDLE on the same edge.
  - Detection of the next start edge resumes from the middle of the stop bit.
- FIFO push when full: the word is discarded and overrun is set.
  - Exception: if a pop happens in the same cycle, the push succeeds and no overrun occurs.
- FIFO timing: registered output, no fall-through. m_valid rises on the cycle after the push edge.
- Simultaneous push and pop: fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- enable = 0: state goes to IDLE and counters clear on the next edge. The partial frame is dropped.
  - FIFO contents, the pop interface and overrun remain active.
- rst_n asserted mid-frame: immediate return to the reset values; FIFO contents are lost.
- Latency: m_valid rises 3 cycles after the baud edge that samples the middle of the last stop bit, measured at the rx pin (2 synchronizer cycles plus 1 FIFO cycle).

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined: a frame with all data bits 0, parity bit 0 (if present) and ferr = 1 is a break.
  - It is not pushed; break_det pulses for 1 cycle.
  - The FSM then waits in a BREAK state until rx_s = 1 before returning to IDLE, so there is exactly one pulse per break.
- Not defined: such a frame is pushed as data 0 with m_frame_err = 1. break_det is tied to 0.

Test Plan:
(all with defaults: OVERSAMPLING=16, DATA_BITS=8, even parity, 1 stop, m_ready=1)
- Clean frame: send 0xA5, parity 0, stop 1 -> one word, m_data = 0xA5, both error flags 0, fifo_count returns to 0.
- Bad parity: send 0x3C with parity bit 1 -> m_data = 0x3C, m_parity_err = 1, m_frame_err = 0.
- Bad stop: send 0x55 with parity 0 and stop bit 0 -> m_data = 0x55, m_frame_err = 1.
- Overrun: m_ready = 0, send 0x01..0x05 -> fifo_count = 4, overrun = 1.
  - Then set m_ready = 1 -> words pop as 0x01..0x04. err_clr pulse -> overrun = 0.
- Glitch and abort:
  - rx low for 4 cycles -> no push, busy back to 0.
  - enable dropped in the middle of data bit 3 -> no push; the next clean 0x7E frame is received correctly.
- Break (macro defined): rx low for 12 bit times -> exactly one break_det pulse, fifo_count = 0.
  - Then send 0x42 -> received normally.
